wordle_guess_ctrl: RTL and testbench

Front-end controller for the Wordle processor. It collects five letter keystrokes into a guess and drives `counter`, `data_guess0-4` and `data_corr0-4` into the register file. It then waits for the processor's `readysignal`, captures `data_color0-4` into a per-row history write, and tracks row, win and lose status. It is the producer and consumer on the opposite side of the register file's Wordle ports.

---
 rtl/wordle_guess_ctrl_pkg.sv | 43 ++++
 rtl/wordle_guess_ctrl_if.sv | 43 ++++
 rtl/wordle_guess_ctrl_rise_detect.sv | 22 ++
 rtl/wordle_guess_ctrl.sv | 143 ++++++++++++++
 tb/tb_wordle_guess_ctrl.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/wordle_guess_ctrl_pkg.sv
// Shared types and constants for the Wordle guess front-end controller.
// Holds color/state enums, sizing constants and the register-file counter encoding.
package wordle_pkg;

    localparam int LETTER_W = 5;
    localparam int COLOR_W  = 2;
    localparam int LETTERS  = 5;
    localparam int MAX_ROWS = 6;

    localparam logic [4:0] OFS_ENTRY  = 5'd0;
    localparam logic [4:0] OFS_STROBE = 5'd4;
    localparam logic [4:0] OFS_WAIT   = 5'd1;
    localparam logic [4:0] OFS_DONE   = 5'd2;

    typedef enum logic [1:0] {
        COLOR_NONE   = 2'd0,
        COLOR_GRAY   = 2'd1,
        COLOR_YELLOW = 2'd2,
        COLOR_GREEN  = 2'd3
    } color_t;

    typedef enum logic [2:0] {
        ENTRY,
        STROBE,
        WAIT,
        CAPTURE,
        WON,
        LOST
    } state_t;

    // The register file decodes 5*row + offset; 5*row is built as (row<<2)+row.
    function automatic logic [4:0] counter_code(input state_t st, input logic [2:0] row);
        logic [4:0] ofs;
        case (st)
            ENTRY:         ofs = OFS_ENTRY;
            STROBE:        ofs = OFS_STROBE;
            WAIT, CAPTURE: ofs = OFS_WAIT;
            default:       ofs = OFS_DONE;
        endcase
        return ({2'b00, row} << 2) + {2'b00, row} + ofs;
    endfunction

endpackage

// File: rtl/wordle_guess_ctrl_if.sv
// Keyboard, game-control and register-file Wordle port bundle.
// master = the guess controller, slave = keyboard / register file / processor side.
interface wordle_guess_ctrl_if;

    logic        new_game;
    logic [24:0] answer_in;
    logic        key_valid;
    logic [4:0]  key_code;
    logic        key_back;
    logic        key_enter;
    logic        readysignal;
    logic [31:0] data_color0, data_color1, data_color2, data_color3, data_color4;

    logic [4:0]  counter;
    logic [31:0] data_corr0, data_corr1, data_corr2, data_corr3, data_corr4;
    logic [31:0] data_guess0, data_guess1, data_guess2, data_guess3, data_guess4;
    logic [2:0]  cur_row;
    logic [2:0]  cur_col;
    logic        hist_we;
    logic [2:0]  hist_row;
    logic [9:0]  hist_colors;
    logic        won;
    logic        lost;

    modport master (
        input  new_game, answer_in, key_valid, key_code, key_back, key_enter, readysignal,
        input  data_color0, data_color1, data_color2, data_color3, data_color4,
        output counter,
        output data_corr0, data_corr1, data_corr2, data_corr3, data_corr4,
        output data_guess0, data_guess1, data_guess2, data_guess3, data_guess4,
        output cur_row, cur_col, hist_we, hist_row, hist_colors, won, lost
    );

    modport slave (
        output new_game, answer_in, key_valid, key_code, key_back, key_enter, readysignal,
        output data_color0, data_color1, data_color2, data_color3, data_color4,
        input  counter,
        input  data_corr0, data_corr1, data_corr2, data_corr3, data_corr4,
        input  data_guess0, data_guess1, data_guess2, data_guess3, data_guess4,
        input  cur_row, cur_col, hist_we, hist_row, hist_colors, won, lost
    );

endinterface

// File: rtl/wordle_guess_ctrl_rise_detect.sv
// 1-bit rising-edge detector: remembers last cycle's sample, flags a 0->1 step.
// The history register clears synchronously with the active-low reset.
module rise_detect (
    input  logic clock,
    input  logic ctrl_reset,
    input  logic din,
    output logic rise
);

    logic prev_q;

    always_ff @(posedge clock) begin
        if (!ctrl_reset) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= din;
        end
    end

    assign rise = din & ~prev_q;

endmodule

// File: rtl/wordle_guess_ctrl.sv
// Wordle guess controller: gathers keystrokes into a guess, hands it to the register
// file, waits for the processor's colors and records them as a per-row history write.
module wordle_guess_ctrl #(
    parameter int MAX_ROWS = 6,
    parameter int LETTERS  = 5
) (
    input  logic               clock,
    input  logic               ctrl_reset,
    wordle_guess_ctrl_if.master bus
);

    import wordle_pkg::*;

    localparam logic [2:0] FULL_COL = 3'(LETTERS);
    localparam logic [2:0] LAST_ROW = 3'(MAX_ROWS - 1);

    state_t              state_q, state_d;
    logic [2:0]          row_q, col_q;
    logic [LETTER_W-1:0] guess_q [LETTERS];
    logic [LETTER_W-1:0] corr_q  [LETTERS];
    logic                hist_we_q;
    logic [2:0]          hist_row_q;
    logic [9:0]          hist_colors_q;
    logic [9:0]          colors_in;
    logic                ready_rise;
    logic                letter_ok;
    logic                all_green;
    logic                unused_color_bits;

    rise_detect u_ready_rise (
        .clock      (clock),
        .ctrl_reset (ctrl_reset),
        .din        (bus.readysignal),
        .rise       (ready_rise)
    );

    assign colors_in = {bus.data_color4[1:0], bus.data_color3[1:0], bus.data_color2[1:0],
                        bus.data_color1[1:0], bus.data_color0[1:0]};
    assign unused_color_bits = ^{bus.data_color4[31:2], bus.data_color3[31:2],
                                 bus.data_color2[31:2], bus.data_color1[31:2],
                                 bus.data_color0[31:2]};
    assign letter_ok = (bus.key_code != 5'd0) && (bus.key_code <= 5'd26);
    assign all_green = (hist_colors_q == '1);

    always_ff @(posedge clock) begin
        if (!ctrl_reset) begin
            state_q <= ENTRY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ENTRY:   if (bus.key_enter && col_q == FULL_COL) state_d = STROBE;
            STROBE:  state_d = WAIT;
            WAIT:    if (ready_rise) state_d = CAPTURE;
            CAPTURE: begin
                if (all_green)              state_d = WON;
                else if (row_q == LAST_ROW) state_d = LOST;
                else                        state_d = ENTRY;
            end
            default: state_d = state_q;
        endcase
        if (bus.new_game) state_d = ENTRY;
    end

    // Enter outranks back, back outranks letter; a blocked enter still swallows the others.
    always_ff @(posedge clock) begin
        if (!ctrl_reset) begin
            row_q         <= '0;
            col_q         <= '0;
            hist_we_q     <= 1'b0;
            hist_row_q    <= '0;
            hist_colors_q <= '0;
            for (int i = 0; i < LETTERS; i++) begin
                guess_q[i] <= '0;
                corr_q[i]  <= '0;
            end
        end else if (bus.new_game) begin
            row_q     <= '0;
            col_q     <= '0;
            hist_we_q <= 1'b0;
            for (int i = 0; i < LETTERS; i++) begin
                guess_q[i] <= '0;
                corr_q[i]  <= bus.answer_in[i*LETTER_W +: LETTER_W];
            end
        end else begin
            hist_we_q <= 1'b0;
            case (state_q)
                ENTRY: begin
                    if (!bus.key_enter) begin
                        if (bus.key_back) begin
                            if (col_q != 3'd0) begin
                                col_q                 <= col_q - 3'd1;
                                guess_q[col_q - 3'd1] <= '0;
                            end
                        end else if (bus.key_valid && letter_ok && col_q < FULL_COL) begin
                            guess_q[col_q] <= bus.key_code;
                            col_q          <= col_q + 3'd1;
                        end
                    end
                end
                WAIT: begin
                    if (ready_rise) begin
                        hist_we_q     <= 1'b1;
                        hist_row_q    <= row_q;
                        hist_colors_q <= colors_in;
                    end
                end
                CAPTURE: begin
                    if (state_d == ENTRY) begin
                        row_q <= row_q + 3'd1;
                        col_q <= '0;
                        for (int i = 0; i < LETTERS; i++) guess_q[i] <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.counter     = counter_code(state_q, row_q);
    assign bus.data_corr0  = 32'(corr_q[0]);
    assign bus.data_corr1  = 32'(corr_q[1]);
    assign bus.data_corr2  = 32'(corr_q[2]);
    assign bus.data_corr3  = 32'(corr_q[3]);
    assign bus.data_corr4  = 32'(corr_q[4]);
    assign bus.data_guess0 = 32'(guess_q[0]);
    assign bus.data_guess1 = 32'(guess_q[1]);
    assign bus.data_guess2 = 32'(guess_q[2]);
    assign bus.data_guess3 = 32'(guess_q[3]);
    assign bus.data_guess4 = 32'(guess_q[4]);
    assign bus.cur_row     = row_q;
    assign bus.cur_col     = col_q;
    assign bus.hist_we     = hist_we_q;
    assign bus.hist_row    = hist_row_q;
    assign bus.hist_colors = hist_colors_q;
    assign bus.won         = (state_q == WON);
    assign bus.lost        = (state_q == LOST);

endmodule

// File: tb/tb_wordle_guess_ctrl.sv
// Self-checking bench for wordle_guess_ctrl: direct checks on entry/handshake/status,
// and a scoreboard queue of expected history writes popped whenever hist_we fires.
module tb_wordle_guess_ctrl;

    logic clock = 1'b0;
    logic ctrl_reset;

    wordle_guess_ctrl_if bus();

    wordle_guess_ctrl #(.MAX_ROWS(6), .LETTERS(5)) dut (
        .clock      (clock),
        .ctrl_reset (ctrl_reset),
        .bus        (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [2:0] row;
        logic [9:0] colors;
    } hist_t;

    hist_t exp_q[$];
    int    num_checks = 0;
    int    num_fail   = 0;

    localparam logic [24:0] CRANE = {5'd5, 5'd14, 5'd1, 5'd18, 5'd3};
    localparam logic [24:0] SLATE = {5'd5, 5'd20, 5'd1, 5'd12, 5'd19};
    localparam logic [24:0] MOUSE = {5'd5, 5'd19, 5'd21, 5'd15, 5'd13};

    task automatic check_output(input string tag, input logic [31:0] actual,
                                input logic [31:0] expected);
        num_checks++;
        if (actual !== expected) begin
            num_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic cycle(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Upper bits carry junk so that only [1:0] may influence the capture.
    task automatic set_colors(input logic [9:0] c);
        bus.data_color0 = {30'h15555555, c[1:0]};
        bus.data_color1 = {30'h2AAAAAAA, c[3:2]};
        bus.data_color2 = {30'h15555555, c[5:4]};
        bus.data_color3 = {30'h2AAAAAAA, c[7:6]};
        bus.data_color4 = {30'h15555555, c[9:8]};
    endtask

    task automatic apply_stimulus(input logic valid, input logic [4:0] code,
                                  input logic back, input logic enter);
        bus.key_valid = valid;
        bus.key_code  = code;
        bus.key_back  = back;
        bus.key_enter = enter;
        cycle();
        bus.key_valid = 1'b0;
        bus.key_back  = 1'b0;
        bus.key_enter = 1'b0;
    endtask

    task automatic start_game(input logic [24:0] answer);
        bus.answer_in = answer;
        bus.new_game  = 1'b1;
        cycle();
        bus.new_game  = 1'b0;
    endtask

    task automatic fill_row(input logic [24:0] word);
        for (int i = 0; i < 5; i++) apply_stimulus(1'b1, word[i*5 +: 5], 1'b0, 1'b0);
    endtask

    // Full row submission: enter, strobe/wait counters, fresh ready edge, settle to s+2.
    task automatic submit_row(input logic [2:0] row, input logic [9:0] colors);
        hist_t e;
        apply_stimulus(1'b0, 5'd0, 1'b0, 1'b1);
        check_output("counter_strobe", 32'(bus.counter), 32'(row) * 5 + 4);
        cycle();
        check_output("counter_wait", 32'(bus.counter), 32'(row) * 5 + 1);
        bus.readysignal = 1'b0;
        cycle();
        set_colors(colors);
        e.row    = row;
        e.colors = colors;
        exp_q.push_back(e);
        bus.readysignal = 1'b1;
        cycle(2);
    endtask

    always @(negedge clock) begin : hist_monitor
        hist_t e;
        if (bus.hist_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_output("hist_unexpected", 32'(bus.hist_we), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check_output("hist_row", 32'(bus.hist_row), 32'(e.row));
                check_output("hist_colors", 32'(bus.hist_colors), 32'(e.colors));
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        hist_t e;
        ctrl_reset      = 1'b0;
        bus.new_game    = 1'b0;
        bus.answer_in   = '0;
        bus.key_valid   = 1'b0;
        bus.key_code    = '0;
        bus.key_back    = 1'b0;
        bus.key_enter   = 1'b0;
        bus.readysignal = 1'b0;
        set_colors(10'd0);
        cycle(2);
        check_output("reset_counter", 32'(bus.counter), 32'd0);
        check_output("reset_row", 32'(bus.cur_row), 32'd0);
        check_output("reset_col", 32'(bus.cur_col), 32'd0);
        check_output("reset_hist_we", 32'(bus.hist_we), 32'd0);
        check_output("reset_won", 32'(bus.won), 32'd0);
        check_output("reset_lost", 32'(bus.lost), 32'd0);
        ctrl_reset = 1'b1;
        cycle();

        $display("[TB] new game CRANE");
        start_game(CRANE);
        check_output("corr0", bus.data_corr0, 32'd3);
        check_output("corr1", bus.data_corr1, 32'd18);
        check_output("corr2", bus.data_corr2, 32'd1);
        check_output("corr3", bus.data_corr3, 32'd14);
        check_output("corr4", bus.data_corr4, 32'd5);
        check_output("counter_new_game", 32'(bus.counter), 32'd0);

        $display("[TB] letter entry and backspace");
        fill_row(SLATE);
        check_output("guess0", bus.data_guess0, 32'd19);
        check_output("guess1", bus.data_guess1, 32'd12);
        check_output("guess2", bus.data_guess2, 32'd1);
        check_output("guess3", bus.data_guess3, 32'd20);
        check_output("guess4", bus.data_guess4, 32'd5);
        check_output("col_full", 32'(bus.cur_col), 32'd5);
        apply_stimulus(1'b1, 5'd24, 1'b0, 1'b0);
        check_output("sixth_key_col", 32'(bus.cur_col), 32'd5);
        check_output("sixth_key_guess4", bus.data_guess4, 32'd5);
        apply_stimulus(1'b0, 5'd0, 1'b1, 1'b0);
        check_output("back_guess4", bus.data_guess4, 32'd0);
        check_output("back_col", 32'(bus.cur_col), 32'd4);
        apply_stimulus(1'b0, 5'd0, 1'b0, 1'b1);
        check_output("short_enter_counter", 32'(bus.counter), 32'd0);
        check_output("short_enter_col", 32'(bus.cur_col), 32'd4);
        apply_stimulus(1'b1, 5'd27, 1'b0, 1'b0);
        check_output("bad_code_col", 32'(bus.cur_col), 32'd4);
        apply_stimulus(1'b1, 5'd5, 1'b0, 1'b0);
        check_output("reenter_col", 32'(bus.cur_col), 32'd5);

        $display("[TB] submission handshake");
        bus.readysignal = 1'b1;
        apply_stimulus(1'b0, 5'd0, 1'b0, 1'b1);
        check_output("hs_counter_strobe", 32'(bus.counter), 32'd4);
        cycle();
        check_output("hs_counter_wait", 32'(bus.counter), 32'd1);
        apply_stimulus(1'b1, 5'd7, 1'b0, 1'b0);
        cycle(3);
        check_output("held_ready_hist_we", 32'(bus.hist_we), 32'd0);
        check_output("held_ready_counter", 32'(bus.counter), 32'd1);
        check_output("wait_keys_col", 32'(bus.cur_col), 32'd5);
        bus.readysignal = 1'b0;
        cycle();
        set_colors(10'b11_01_11_01_01);
        e.row    = 3'd0;
        e.colors = 10'b11_01_11_01_01;
        exp_q.push_back(e);
        bus.readysignal = 1'b1;
        cycle();
        check_output("hist_we_pulse", 32'(bus.hist_we), 32'd1);
        cycle();
        check_output("next_row", 32'(bus.cur_row), 32'd1);
        check_output("next_counter", 32'(bus.counter), 32'd5);
        check_output("next_col", 32'(bus.cur_col), 32'd0);
        check_output("next_guess0", bus.data_guess0, 32'd0);
        check_output("next_guess4", bus.data_guess4, 32'd0);
        check_output("next_hist_we", 32'(bus.hist_we), 32'd0);

        $display("[TB] rows 1 and 2, win");
        fill_row(MOUSE);
        submit_row(3'd1, 10'b10_10_10_10_10);
        check_output("row2", 32'(bus.cur_row), 32'd2);
        check_output("row2_counter", 32'(bus.counter), 32'd10);
        fill_row(CRANE);
        submit_row(3'd2, 10'b11_11_11_11_11);
        check_output("win_won", 32'(bus.won), 32'd1);
        check_output("win_lost", 32'(bus.lost), 32'd0);
        check_output("win_counter", 32'(bus.counter), 32'd12);
        check_output("win_row", 32'(bus.cur_row), 32'd2);
        apply_stimulus(1'b0, 5'd0, 1'b1, 1'b0);
        apply_stimulus(1'b1, 5'd9, 1'b0, 1'b0);
        cycle(3);
        check_output("win_keys_col", 32'(bus.cur_col), 32'd5);
        check_output("win_guess_held", bus.data_guess0, 32'd3);
        check_output("win_sticky", 32'(bus.won), 32'd1);

        $display("[TB] six misses, lose");
        start_game(MOUSE);
        check_output("ng_won", 32'(bus.won), 32'd0);
        check_output("ng_row", 32'(bus.cur_row), 32'd0);
        check_output("ng_guess0", bus.data_guess0, 32'd0);
        check_output("ng_corr0", bus.data_corr0, 32'd13);
        for (int r = 0; r < 6; r++) begin
            fill_row(SLATE);
            submit_row(3'(r), 10'b11_11_11_01_11);
            if (r < 5) begin
                check_output("miss_counter", 32'(bus.counter), 32'(r + 1) * 5);
                check_output("miss_lost", 32'(bus.lost), 32'd0);
            end
        end
        check_output("lose_lost", 32'(bus.lost), 32'd1);
        check_output("lose_won", 32'(bus.won), 32'd0);
        check_output("lose_counter", 32'(bus.counter), 32'd27);
        check_output("lose_row", 32'(bus.cur_row), 32'd5);

        $display("[TB] simultaneous strobes");
        start_game(CRANE);
        apply_stimulus(1'b1, 5'd8, 1'b0, 1'b0);
        apply_stimulus(1'b1, 5'd9, 1'b0, 1'b0);
        check_output("two_letters_col", 32'(bus.cur_col), 32'd2);
        apply_stimulus(1'b1, 5'd10, 1'b1, 1'b0);
        check_output("back_letter_col", 32'(bus.cur_col), 32'd1);
        check_output("back_letter_guess1", bus.data_guess1, 32'd0);
        check_output("back_letter_guess0", bus.data_guess0, 32'd8);
        apply_stimulus(1'b1, 5'd10, 1'b1, 1'b1);
        check_output("enter_back_letter_col", 32'(bus.cur_col), 32'd1);
        check_output("enter_back_letter_counter", 32'(bus.counter), 32'd0);

        $display("[TB] reset during wait");
        for (int i = 0; i < 4; i++) apply_stimulus(1'b1, 5'(i + 2), 1'b0, 1'b0);
        bus.readysignal = 1'b0;
        apply_stimulus(1'b0, 5'd0, 1'b0, 1'b1);
        cycle();
        check_output("abort_wait_counter", 32'(bus.counter), 32'd1);
        ctrl_reset      = 1'b0;
        bus.new_game    = 1'b1;
        bus.answer_in   = MOUSE;
        bus.readysignal = 1'b1;
        cycle();
        ctrl_reset   = 1'b1;
        bus.new_game = 1'b0;
        check_output("abort_counter", 32'(bus.counter), 32'd0);
        check_output("abort_row", 32'(bus.cur_row), 32'd0);
        check_output("abort_col", 32'(bus.cur_col), 32'd0);
        check_output("abort_corr0", bus.data_corr0, 32'd0);
        check_output("abort_guess0", bus.data_guess0, 32'd0);
        check_output("abort_hist_we", 32'(bus.hist_we), 32'd0);
        check_output("abort_hist_row", 32'(bus.hist_row), 32'd0);
        check_output("abort_hist_colors", 32'(bus.hist_colors), 32'd0);
        check_output("abort_won", 32'(bus.won), 32'd0);
        check_output("abort_lost", 32'(bus.lost), 32'd0);
        cycle(3);
        check_output("abort_no_hist", 32'(bus.hist_we), 32'd0);

        check_output("hist_pending", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
        $finish;
    end

endmodule
